// File: rtl/dmem_burst_reader.sv
// Burst fetch front-end for the 8-wide data memory: walks line addresses,
// captures each 256-bit line and serialises it onto a 32-bit valid/ready stream.
module dmem_burst_reader #(
  parameter int data_width  = 32,
  parameter int addr_width  = 15,
  parameter int count_width = 16
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_REQ_VALID,
  output logic                      o_REQ_READY,
  input  logic [addr_width-1:0]     i_REQ_ADDR,
  input  logic [count_width-1:0]    i_REQ_COUNT,
  output logic [addr_width-1:0]     o_MEM_ADDR,
  input  logic [8*data_width-1:0]   i_MEM_DATA,
  output logic [data_width-1:0]     o_DATA,
  output logic                      o_VALID,
  input  logic                      i_READY,
  output logic                      o_LAST,
  output logic                      o_DONE
);
  localparam int LINE_WORDS = 8;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPTURE, S_DRAIN, S_FINISH} state_t;

  state_t                          state_q, state_d;
  logic [addr_width-1:0]           addr_q, addr_d;
  logic [count_width-1:0]          rem_q, rem_d;
  logic [2:0]                      idx_q, idx_d;
  logic [3:0]                      len_q, len_d;
  logic [LINE_WORDS*data_width-1:0] line_q, line_d;
  logic [data_width-1:0]           data_q, data_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic                            done_q, done_d;
  logic                            ready_q, ready_d;

  logic [data_width-1:0]           line_words [LINE_WORDS];
  logic [3:0]                      idx_inc;
  logic [count_width-1:0]          rem_dec;

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
    assign line_words[gi] = line_q[gi*data_width +: data_width];
  end

  assign idx_inc = {1'b0, idx_q} + 4'd1;
  // Gated decrement keeps the remaining count from wrapping below zero.
  assign rem_dec = (rem_q != '0) ? rem_q - count_width'(1) : rem_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      line_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      line_q  <= line_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    len_d   = len_q;
    line_d  = line_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_REQ_VALID && ready_q) begin
          rem_d  = i_REQ_COUNT;
          addr_d = i_REQ_ADDR;
          if (i_REQ_COUNT == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        line_d  = i_MEM_DATA;
        idx_d   = '0;
        len_d   = (rem_q >= count_width'(LINE_WORDS)) ? 4'd8 : rem_q[3:0];
        data_d  = i_MEM_DATA[data_width-1:0];
        valid_d = 1'b1;
        last_d  = (rem_q == count_width'(1));
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (valid_q && i_READY) begin
          rem_d = rem_dec;
          idx_d = idx_inc[2:0];
          if (idx_inc == len_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (rem_dec == '0) begin
              state_d = S_FINISH;
              done_d  = 1'b1;
            end else begin
              addr_d  = addr_q + addr_width'(LINE_WORDS);
              state_d = S_ADDR;
            end
          end else begin
            data_d = line_words[idx_inc[2:0]];
            last_d = (rem_dec == count_width'(1));
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  assign o_REQ_READY = ready_q;
  assign o_MEM_ADDR  = addr_q;
  assign o_DATA      = data_q;
  assign o_VALID     = valid_q;
  assign o_LAST      = last_q;
  assign o_DONE      = done_q;

endmodule

// File: tb/tb_dmem_burst_reader.sv
// Self-checking bench for dmem_burst_reader: table of directed bursts, random
// bursts against a word-queue reference, and a mid-burst reset sequence.
module tb_dmem_burst_reader;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int CW = 16;

  logic            i_CLK = 1'b0;
  logic            i_RST = 1'b1;
  logic            i_REQ_VALID = 1'b0;
  logic            o_REQ_READY;
  logic [AW-1:0]   i_REQ_ADDR = '0;
  logic [CW-1:0]   i_REQ_COUNT = '0;
  logic [AW-1:0]   o_MEM_ADDR;
  logic [8*DW-1:0] mem_line = '0;
  logic [DW-1:0]   o_DATA;
  logic            o_VALID;
  logic            i_READY = 1'b0;
  logic            o_LAST;
  logic            o_DONE;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_burst_reader #(.data_width(DW), .addr_width(AW), .count_width(CW)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_REQ_VALID(i_REQ_VALID), .o_REQ_READY(o_REQ_READY),
    .i_REQ_ADDR(i_REQ_ADDR), .i_REQ_COUNT(i_REQ_COUNT),
    .o_MEM_ADDR(o_MEM_ADDR), .i_MEM_DATA(mem_line),
    .o_DATA(o_DATA), .o_VALID(o_VALID), .i_READY(i_READY),
    .o_LAST(o_LAST), .o_DONE(o_DONE)
  );

  always #5 i_CLK = ~i_CLK;

  // Memory contents are a fixed function of the word address.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {1'b1, a, a ^ 15'h2B3C, 1'b0};
  endfunction

  function automatic logic [8*DW-1:0] line_of(input logic [AW-1:0] a);
    logic [8*DW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*DW +: DW] = memf(a + AW'(k));
    return l;
  endfunction

  // Registered-read memory: samples the address on every edge.
  always @(posedge i_CLK) mem_line <= line_of(o_MEM_ADDR);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_VALID), 64'd0);
    chk({tag, "_data"}, 64'(o_DATA), 64'd0);
    chk({tag, "_last"}, 64'(o_LAST), 64'd0);
    chk({tag, "_done"}, 64'(o_DONE), 64'd0);
    chk({tag, "_reqrdy"}, 64'(o_REQ_READY), 64'd1);
    chk({tag, "_maddr"}, 64'(o_MEM_ADDR), 64'd0);
  endtask

  // Called at a negedge with the DUT idle. mode: 0 ready=1, 1 fixed toggle
  // pattern 1,0,0,1,0,1,1 from the first valid cycle, 2 random ready.
  task automatic run_burst(input logic [AW-1:0] base, input int cnt, input int mode,
                           input int exp_first, input int exp_done);
    logic [DW-1:0] expq[$];
    logic [6:0]    pat = 7'b1101001;
    logic          r, prev_stall, prev_last, busy_rdy_bad, both_bad;
    logic [DW-1:0] prev_data;
    int cyc, first_valid, ndone, done_cyc, xfers, pidx;
    for (int i = 0; i < cnt; i++) expq.push_back(memf(base + AW'(i)));
    chk("req_ready_idle", 64'(o_REQ_READY), 64'd1);
    i_REQ_VALID = 1'b1; i_REQ_ADDR = base; i_REQ_COUNT = CW'(cnt); i_READY = 1'b0;
    @(posedge i_CLK);
    @(negedge i_CLK);
    cyc = 1; first_valid = -1; ndone = 0; done_cyc = -1; xfers = 0; pidx = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; busy_rdy_bad = 1'b0; both_bad = 1'b0;
    while (cyc < 2000) begin
      if (cyc == 1) chk("mem_addr_first", 64'(o_MEM_ADDR), 64'(base));
      if (o_REQ_READY) busy_rdy_bad = 1'b1;
      if (o_DONE && o_LAST) both_bad = 1'b1;
      if (prev_stall) begin
        chk("stall_valid", 64'(o_VALID), 64'd1);
        chk("stall_data", 64'(o_DATA), 64'(prev_data));
        chk("stall_last", 64'(o_LAST), 64'(prev_last));
      end
      if (o_VALID && first_valid < 0) first_valid = cyc;
      case (mode)
        0:       r = 1'b1;
        1:       r = (first_valid >= 0) ? pat[pidx % 7] : 1'b0;
        default: r = ($urandom_range(0, 9) < 7);
      endcase
      if (first_valid >= 0) pidx++;
      i_READY = r;
      // Junk requests while busy must be ignored.
      i_REQ_VALID = 1'($urandom_range(0, 1));
      i_REQ_ADDR = AW'($urandom);
      i_REQ_COUNT = CW'($urandom_range(1, 50));
      if (o_VALID && r) begin
        if (expq.size() == 0) begin
          chk("extra_word", 64'(o_DATA), 64'd0);
          chk("extra_word_valid", 64'(o_VALID), 64'd0);
        end else begin
          chk("word_data", 64'(o_DATA), 64'(expq.pop_front()));
          chk("word_last", 64'(o_LAST), 64'(expq.size() == 0));
        end
        xfers++;
      end
      prev_stall = o_VALID && !r;
      prev_data = o_DATA;
      prev_last = o_LAST;
      if (o_DONE) begin
        ndone = 1;
        done_cyc = cyc;
        break;
      end
      @(negedge i_CLK);
      cyc++;
    end
    i_REQ_VALID = 1'b0; i_READY = 1'b0;
    chk("done_seen", 64'(ndone), 64'd1);
    chk("xfer_count", 64'(xfers), 64'(cnt));
    chk("first_valid_cycle", 64'(first_valid), 64'(exp_first));
    if (exp_done >= 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("reqrdy_low_busy", 64'(busy_rdy_bad), 64'd0);
    chk("last_done_overlap", 64'(both_bad), 64'd0);
    @(negedge i_CLK);
    chk("reqrdy_after", 64'(o_REQ_READY), 64'd1);
    chk("done_pulse_1cyc", 64'(o_DONE), 64'd0);
    $display("burst base=0x%04h count=%0d mode=%0d words=%0d done_cycle=%0d",
             base, cnt, mode, xfers, done_cyc);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            cnt;
    int            mode;
    int            exp_first;
    int            exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int x, guard, cnt, mode;
    logic bad;
    logic [AW-1:0] b;

    vecs[0] = '{15'h0010, 8,  0, 3,  11};
    vecs[1] = '{15'h0100, 13, 0, 3,  18};
    vecs[2] = '{15'h0020, 4,  1, 3,  10};
    vecs[3] = '{15'h0050, 0,  0, -1, 1};
    vecs[4] = '{15'h7FFC, 8,  0, 3,  11};
    vecs[5] = '{15'h7FFA, 20, 2, 3,  -1};

    @(negedge i_CLK);
    check_reset_outputs("reset");
    @(negedge i_CLK);
    i_RST = 1'b0;
    @(negedge i_CLK);

    for (int i = 0; i < 6; i++)
      run_burst(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].exp_first, vecs[i].exp_done);

    for (int i = 0; i < 10; i++) begin
      b = AW'($urandom);
      cnt = $urandom_range(0, 40);
      mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run_burst(b, cnt, mode, (cnt == 0) ? -1 : 3,
                (mode != 0) ? -1 : ((cnt == 0) ? 1 : 2 * ((cnt + 7) / 8) + cnt + 1));
    end

    // Reset in the middle of a 16-word burst after the third transfer.
    i_REQ_VALID = 1'b1; i_REQ_ADDR = '0; i_REQ_COUNT = 16; i_READY = 1'b1;
    @(posedge i_CLK); #1;
    i_REQ_VALID = 1'b0;
    x = 0; guard = 0;
    while (x < 3 && guard < 100) begin
      if (o_VALID) begin
        chk("rst_pre_word", 64'(o_DATA), 64'(memf(AW'(x))));
        x++;
      end
      @(posedge i_CLK); #1;
      guard++;
    end
    chk("rst_pre_xfers", 64'(x), 64'd3);
    i_RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_CLK);
      if (o_VALID || o_DONE || !o_REQ_READY) bad = 1'b1;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);
    $display("burst base=0x0000 count=16 aborted by reset after %0d words", x);
    run_burst(15'h0040, 2, 0, 3, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_burst_reader.md
Name: dmem_burst_reader

Overview:
- Sequential fetch front-end for the 8-wide read-only data memory.
- Accepts a burst request (base word address, word count) and drives the memory's address input one 8-word line at a time.
- Captures each 256-bit line and serialises it onto a 32-bit valid/ready stream with backpressure.
- Sits directly downstream of the data memory. It owns that memory's address port and consumes its eight read outputs.

Parameters:
data_width, 32, width of one memory word and of the output stream
addr_width, 15, word-address width; must match the data memory
count_width, 16, width of the burst word count (max burst 2**addr_width words)

Ports:
i_CLK  input  1  single clock; also drives the data memory read clock
i_RST  input  1  asynchronous, active-high reset
i_REQ_VALID  input  1  burst request valid
o_REQ_READY  output  1  block can accept a request
i_REQ_ADDR  input  addr_width  base word address of the burst
i_REQ_COUNT  input  count_width  number of words to deliver
o_MEM_ADDR  output  addr_width  line address to the data memory
i_MEM_DATA  input  8*data_width  the memory's eight read words concatenated; word a (offset 0) in [31:0], word h (offset 7) in [255:224]
o_DATA  output  data_width  stream word
o_VALID  output  1  stream word valid
i_READY  input  1  downstream accepts the word
o_LAST  output  1  final word of the burst, qualified by o_VALID
o_DONE  output  1  one-cycle pulse when the burst completes

Behaviour:
- Reset (async, i_RST=1):
  - State goes to IDLE.
  - o_MEM_ADDR=0, o_DATA=0, o_VALID=0, o_LAST=0, o_DONE=0, o_REQ_READY=1.
  - Internal remaining count and word index are cleared.
  - Reset mid-burst abandons the burst immediately. No o_DONE and no further words are produced.
- All other outputs are registered.
- States and transitions:
  - IDLE: o_REQ_READY=1.
    - On i_REQ_VALID&o_REQ_READY, latch the count and set o_MEM_ADDR<=i_REQ_ADDR.
    - If count=0, go to FINISH; otherwise go to ADDR.
  - ADDR: 1 cycle. The memory samples o_MEM_ADDR on this edge. Go to CAPTURE.
  - CAPTURE: 1 cycle.
    - Latch i_MEM_DATA into an 8-word line buffer.
    - Set word index=0 and line_len=min(8, remaining).
    - Drive o_DATA=word 0, o_VALID=1, and o_LAST=(remaining==1). Go to DRAIN.
  - DRAIN: a word transfers on o_VALID&i_READY. On each transfer, decrement remaining and increment the index.
    - If the index reaches line_len and remaining=0: go to FINISH with o_VALID=0.
    - If the index reaches line_len and remaining>0: o_MEM_ADDR<=o_MEM_ADDR+8, o_VALID=0, go to ADDR.
    - Otherwise: present the next word, with o_LAST=(remaining==1 after decrement).
    - While i_READY=0, o_DATA, o_VALID and o_LAST hold stable.
  - FINISH: 1 cycle. o_DONE=1, then go to IDLE.
- Latency:
  - First o_VALID is asserted 2 edges after the accepting edge.
  - Each subsequent line adds 2 idle cycles (ADDR and CAPTURE) between its words and the previous line's.
  - Full-throughput line rate is 8 words per 10 cycles.
- Arithmetic:
  - o_MEM_ADDR increments modulo 2**addr_width, so it wraps past the top of memory.
  - Words within a line follow the memory's own modulo addressing. The burst at 0x7FFC therefore yields 0x7FFC..0x7FFF, then 0x0000..0x0003.
  - The remaining count is count_width bits and never underflows, because its decrement is gated by remaining>0.
- A new request is never accepted outside IDLE. i_REQ_* are ignored while busy.
- o_LAST and o_DONE never assert together in the same cycle.

Test Plan:
- Base 0x0010, count 8, i_READY=1 → o_VALID high for 8 consecutive cycles starting 2 edges after accept.
  - Words equal mem[0x10..0x17]; o_LAST on the 8th; o_DONE one cycle later; o_REQ_READY returns to 1.
- Base 0x0100, count 13, i_READY=1 → mem[0x100..0x107], then a 2-cycle gap, then mem[0x108..0x10C].
  - o_MEM_ADDR is 0x0100 then 0x0108; o_LAST on word 13.
- Base 0x0020, count 4, i_READY toggling 1,0,0,1,0,1,1 → exactly 4 transfers in order mem[0x20..0x23].
  - o_DATA is stable during every stall cycle.
- Count 0 at base 0x0050 → no o_VALID; o_DONE pulses 1 cycle after accept.
- Base 0x7FFC, count 8 → words mem[0x7FFC..0x7FFF], mem[0x0000..0x0003].
- Base 0x0000, count 16, assert i_RST after the 3rd transfer → all outputs go to reset values.
  - No o_DONE is produced.
  - A new request for count 2 at 0x0040 then completes normally.
